// File: rtl/pong_game_controller_pkg.sv
// Shared screen, pad and ball geometry for the pong game controller.
// Also holds the game-state and sequencer codes.
package pong_game_controller_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PAD_DIST = 16;
    localparam int PAD_W    = 8;
    localparam int PAD_H    = 64;
    localparam int BALL_R   = 8;

    localparam int CENTRE_X = SCREEN_W / 2;
    localparam int CENTRE_Y = SCREEN_H / 2;

    localparam int PAD_MIN = PAD_H / 2;
    localparam int PAD_MAX = SCREEN_H - PAD_H / 2 - 1;

    // Ball centre x where it touches a pad face.
    localparam int HIT_LEFT  = PAD_DIST + PAD_W + BALL_R;
    localparam int HIT_RIGHT = SCREEN_W - HIT_LEFT;
    localparam int HIT_SPAN  = PAD_H / 2 + BALL_R;

    localparam int WALL_TOP   = BALL_R;
    localparam int WALL_BOT   = SCREEN_H - BALL_R - 1;
    localparam int MISS_LEFT  = BALL_R;
    localparam int MISS_RIGHT = SCREEN_W - BALL_R - 1;

    localparam logic [1:0] GS_SERVE = 2'd0;
    localparam logic [1:0] GS_PLAY  = 2'd1;
    localparam logic [1:0] GS_OVER  = 2'd2;

    localparam logic [2:0] SEQ_IDLE    = 3'd0;
    localparam logic [2:0] SEQ_PADS    = 3'd1;
    localparam logic [2:0] SEQ_BALL    = 3'd2;
    localparam logic [2:0] SEQ_COLLIDE = 3'd3;
    localparam logic [2:0] SEQ_COMMIT  = 3'd4;

    typedef logic signed [11:0] coord_t;

    function automatic coord_t abs12(input coord_t v);
        return v[11] ? -v : v;
    endfunction

endpackage

// File: rtl/pong_game_controller_pad_mover.sv
// One pad's per-frame step: move by the button pair, then clamp
// the centre so the whole pad stays on screen.
module pad_mover
    import pong_game_controller_pkg::*;
#(
    parameter int PAD_SPEED = 4
) (
    input  logic [8:0] pad,
    input  logic [1:0] btn,
    output logic [8:0] pad_next
);

    coord_t y;

    always_comb begin
        y = coord_t'({3'b000, pad});
        unique case (btn)
            2'b10:   y = y - coord_t'(PAD_SPEED);
            2'b01:   y = y + coord_t'(PAD_SPEED);
            default: y = coord_t'({3'b000, pad});
        endcase
        if (y < coord_t'(PAD_MIN)) begin
            y = coord_t'(PAD_MIN);
        end else if (y > coord_t'(PAD_MAX)) begin
            y = coord_t'(PAD_MAX);
        end
        pad_next = y[8:0];
    end

endmodule

// File: rtl/pong_game_controller.sv
// Per-frame pong state sequencer; results are committed only once per
// frame_start, inside vertical blank, so the picture never tears.
module pong_game_controller
    import pong_game_controller_pkg::*;
#(
    parameter int PAD_SPEED    = 4,
    parameter int BALL_SPEED_X = 3,
    parameter int BALL_SPEED_Y = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [1:0] btn_left,
    input  logic [1:0] btn_right,
    output logic [8:0] pad_left,
    output logic [8:0] pad_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] game_state,
    output logic       busy
);

    localparam coord_t VX = coord_t'(BALL_SPEED_X);
    localparam coord_t VY = coord_t'(BALL_SPEED_Y);

    logic [2:0]  seq;
    logic [15:0] serve_cnt;
    coord_t      vx, vy, nx, ny;
    logic [8:0]  pl_step, pr_step, pl_n, pr_n;
    logic [9:0]  col_x;
    logic [8:0]  col_y;
    coord_t      col_vx, col_vy;
    logic        pt_left, pt_right;

    coord_t      bx, by, cx, cy, cvx, cvy;
    logic        hit_l, hit_r, pt_left_c, pt_right_c;
    logic [3:0]  sl_inc, sr_inc;

    pad_mover #(.PAD_SPEED(PAD_SPEED)) u_pad_left (
        .pad      (pad_left),
        .btn      (btn_left),
        .pad_next (pl_step)
    );

    pad_mover #(.PAD_SPEED(PAD_SPEED)) u_pad_right (
        .pad      (pad_right),
        .btn      (btn_right),
        .pad_next (pr_step)
    );

    assign busy   = (seq != SEQ_IDLE);
    assign sl_inc = score_left + 4'd1;
    assign sr_inc = score_right + 4'd1;

    // Walls first, then pads against the clamped y, so corner hits
    // reflect on both axes in one frame.
    always_comb begin
        bx  = coord_t'({2'b00, ball_x});
        by  = coord_t'({3'b000, ball_y});
        cx  = nx;
        cy  = ny;
        cvx = vx;
        cvy = vy;
        if (ny < coord_t'(WALL_TOP)) begin
            cy  = coord_t'(WALL_TOP);
            cvy = VY;
        end else if (ny > coord_t'(WALL_BOT)) begin
            cy  = coord_t'(WALL_BOT);
            cvy = -VY;
        end
        hit_l = vx[11]
             && (bx >= coord_t'(HIT_LEFT))
             && (nx < coord_t'(HIT_LEFT))
             && (abs12(cy - coord_t'({3'b000, pl_n}))
                 < coord_t'(HIT_SPAN));
        hit_r = !vx[11] && (vx != '0)
             && (bx <= coord_t'(HIT_RIGHT))
             && (nx > coord_t'(HIT_RIGHT))
             && (abs12(cy - coord_t'({3'b000, pr_n}))
                 < coord_t'(HIT_SPAN));
        if (hit_l) begin
            cx  = coord_t'(HIT_LEFT);
            cvx = VX;
        end else if (hit_r) begin
            cx  = coord_t'(HIT_RIGHT);
            cvx = -VX;
        end
        pt_right_c = (game_state == GS_PLAY)
                  && (cx <= coord_t'(MISS_LEFT));
        pt_left_c  = (game_state == GS_PLAY)
                  && (cx >= coord_t'(MISS_RIGHT));
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            seq         <= SEQ_IDLE;
            pad_left    <= 9'(CENTRE_Y);
            pad_right   <= 9'(CENTRE_Y);
            ball_x      <= 10'(CENTRE_X);
            ball_y      <= 9'(CENTRE_Y);
            score_left  <= '0;
            score_right <= '0;
            game_state  <= GS_SERVE;
            serve_cnt   <= 16'(SERVE_FRAMES);
            vx          <= VX;
            vy          <= VY;
            nx          <= coord_t'(CENTRE_X);
            ny          <= coord_t'(CENTRE_Y);
            pl_n        <= 9'(CENTRE_Y);
            pr_n        <= 9'(CENTRE_Y);
            col_x       <= 10'(CENTRE_X);
            col_y       <= 9'(CENTRE_Y);
            col_vx      <= VX;
            col_vy      <= VY;
            pt_left     <= 1'b0;
            pt_right    <= 1'b0;
        end else begin
            unique case (seq)
                SEQ_IDLE: begin
                    if (frame_start) seq <= SEQ_PADS;
                end
                SEQ_PADS: begin
                    pl_n <= (game_state == GS_OVER) ? pad_left : pl_step;
                    pr_n <= (game_state == GS_OVER) ? pad_right : pr_step;
                    seq  <= SEQ_BALL;
                end
                SEQ_BALL: begin
                    if (game_state == GS_PLAY) begin
                        nx <= bx + vx;
                        ny <= by + vy;
                    end else begin
                        nx <= coord_t'(CENTRE_X);
                        ny <= coord_t'(CENTRE_Y);
                    end
                    seq <= SEQ_COLLIDE;
                end
                SEQ_COLLIDE: begin
                    col_x    <= cx[9:0];
                    col_y    <= cy[8:0];
                    col_vx   <= cvx;
                    col_vy   <= cvy;
                    pt_left  <= pt_left_c;
                    pt_right <= pt_right_c;
                    seq      <= SEQ_COMMIT;
                end
                SEQ_COMMIT: begin
                    pad_left  <= pl_n;
                    pad_right <= pr_n;
                    if (pt_right || pt_left) begin
                        ball_x <= 10'(CENTRE_X);
                        ball_y <= 9'(CENTRE_Y);
                        vy     <= VY;
                        serve_cnt <= 16'(SERVE_FRAMES);
                        game_state <= GS_SERVE;
                        // Relaunch toward whoever conceded.
                        if (pt_right) begin
                            score_right <= sr_inc;
                            vx <= -VX;
                            if (sr_inc == 4'(WIN_SCORE)) game_state <= GS_OVER;
                        end else begin
                            score_left <= sl_inc;
                            vx <= VX;
                            if (sl_inc == 4'(WIN_SCORE)) game_state <= GS_OVER;
                        end
                    end else begin
                        ball_x <= col_x;
                        ball_y <= col_y;
                        vx     <= col_vx;
                        vy     <= col_vy;
                        if (game_state == GS_SERVE) begin
                            if (serve_cnt != '0) serve_cnt <= serve_cnt - 16'd1;
                            if (serve_cnt <= 16'd1) game_state <= GS_PLAY;
                        end
                    end
                    seq <= SEQ_IDLE;
                end
                default: seq <= SEQ_IDLE;
            endcase
        end
    end

endmodule
